// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 encryptor: one round per clock, on-the-fly key expansion,
// combinational GF(2^8)-inverse S-boxes, valid/ready on both sides.
module aes_enc_iter #(
    parameter bit SUPPORT_256 = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         key_size,
    input  logic [255:0] key,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [255:0] win_q, win_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         is256_q, is256_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 = x^-1 in GF(2^8); maps 0 to 0 without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [127:0] sb, sr, mc, rk, rnd_out, rk_new;
    logic [31:0]  ks_in, ks_sub, ks_t;
    logic [31:0]  w0, w1, w2, w3;
    logic         last, use_rot, accept;

    // Round datapath: 16 state S-boxes, ShiftRows, MixColumns.
    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    // AES-128 derives the current key from the upper half; AES-256 holds the current
    // key in the lower half and derives the next one (rcon on odd rounds only).
    assign ks_in = is256_q ? win_q[31:0] : win_q[159:128];

    for (genvar i = 0; i < 4; i++) begin : g_ksub
        assign ks_sub[31-8*i -: 8] = sbox(ks_in[31-8*i -: 8]);
    end

    assign use_rot = !is256_q || round_q[0];
    assign ks_t    = use_rot ? ({ks_sub[23:0], ks_sub[31:24]} ^ {rcon_q, 24'h000000}) : ks_sub;
    assign w0      = win_q[255:224] ^ ks_t;
    assign w1      = win_q[223:192] ^ w0;
    assign w2      = win_q[191:160] ^ w1;
    assign w3      = win_q[159:128] ^ w2;
    assign rk_new  = {w0, w1, w2, w3};
    assign rk      = is256_q ? win_q[127:0] : rk_new;

    assign last    = round_q == (is256_q ? 4'd14 : 4'd10);
    assign rnd_out = (last ? sr : mc) ^ rk;
    assign accept  = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        is256_d = is256_q;
        if (accept) begin
            is256_d = SUPPORT_256 && key_size;
            state_d = data_in ^ key[255:128];
            win_d   = key;
            round_d = 4'd1;
            rcon_d  = 8'h01;
        end else if (fsm_q == StRound) begin
            state_d = rnd_out;
            round_d = round_q + 4'd1;
            win_d   = is256_q ? {win_q[127:0], rk_new} : {rk_new, win_q[127:0]};
            if (use_rot) rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            win_q   <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
            is256_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            is256_q <= is256_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= StIdle;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            StIdle:  if (in_valid) fsm_d = StRound;
            StRound: if (last) fsm_d = StDone;
            StDone:  if (out_ready) fsm_d = in_valid ? StRound : StIdle;
            default: fsm_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (fsm_q == StIdle) || ((fsm_q == StDone) && out_ready);
        out_valid = fsm_q == StDone;
        busy      = fsm_q != StIdle;
        data_out  = state_q;
    end

endmodule
